ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one single-port RAM (ram_1port-style: 8-bit address, 8-bit data, wren, registered read) between two requesters.
- Requester 0 is the memory test engine; requester 1 is the functional datapath.
- Provides round-robin arbitration, a lock for atomic read-then-write sequences, and tagged read-data return.
- Sits between the requesters and the RAM instance. It owns the RAM address, data and wren exclusively.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- RD_LAT, 1, cycles from the edge at which ram_addr is presented to the RAM until ram_q is valid (legal 1..3).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- r0_req  input  1  requester 0 command valid.
- r0_we  input  1  1 = write, 0 = read.
- r0_lock  input  1  keep ownership after this transfer.
- r0_addr  input  AW  address.
- r0_wdata  input  DW  write data.
- r0_gnt  output  1  command accepted this cycle (combinational).
- r0_rvalid  output  1  read data valid, 1-cycle pulse.
- r0_rdata  output  DW  read data.
- r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same as the r0_* ports, for requester 1.
- ram_addr  output  AW  registered RAM address.
- ram_wdata  output  DW  registered RAM write data.
- ram_wren  output  1  registered RAM write enable.
- ram_q  input  DW  RAM read data.
- owner_valid  output  1  a lock is held.
- owner_id  output  1  holder of the lock.

Behaviour:
- Handshake:
  - A transfer is accepted on a rising edge where rX_req && rX_gnt.
  - The requester holds we, addr, wdata and lock stable while req=1 and gnt=0.
  - At most one transfer is accepted per cycle; back-to-back acceptance by the same requester is allowed.
- Grant, combinational, with rr_ptr = priority holder:
  - owner_valid=1: only owner_id may be granted.
  - owner_valid=0 and a single requester: that requester is granted.
  - owner_valid=0 and both requesting: requester rr_ptr is granted.
  - Neither gnt is ever high when reset=1.
- Round-robin:
  - On each accepted transfer with owner_valid=0 after the edge, rr_ptr <= the other requester.
  - rr_ptr does not change while a lock is held.
- Lock:
  - Accepting a transfer with lock=1 sets owner_valid=1 and owner_id=granted id.
  - Accepting the owner's transfer with lock=0 clears owner_valid on the same edge; rr_ptr then moves to the other requester.
  - While locked, the non-owner's req is ignored, with no timeout.
  - The owner deasserting req does not release the lock.
- RAM command:
  - On the accept edge, ram_addr/ram_wdata/ram_wren are loaded from the winner, with ram_wren = winner we.
  - With no accept: ram_wren <= 0, and ram_addr/ram_wdata hold their values.
- Read return:
  - A read accepted at edge N asserts rX_rvalid for the cycle after edge N+RD_LAT, with rX_rdata = ram_q in that cycle.
  - A shift pipeline of depth RD_LAT carries {valid, id}.
  - Returns arrive in acceptance order; r0_rvalid and r1_rvalid are never both high.
  - rX_rdata holds its last value when rvalid=0.
- Writes: no response; gnt is the completion indication.
- Reset (synchronous, highest priority, legal mid-transfer):
  - ram_wren=0, ram_addr=0, ram_wdata=0.
  - rr_ptr=0, owner_valid=0, owner_id=0.
  - Return pipeline cleared, so in-flight reads never produce rvalid.
  - rX_rvalid=0, rX_rdata=0.
- Address wrap is the requesters' responsibility; the arbiter passes addresses unmodified.

Test Plan:
- Reset, then r0 writes 0x55 to addr 0x00, then reads addr 0x00 -> r0_gnt high on both cycles; ram_wren=1 one cycle after the first accept; r0_rvalid with r0_rdata=0x55 at accept+RD_LAT+1; r1_rvalid stays 0.
- r0_req and r1_req held high continuously, both doing reads of distinct addresses -> grants alternate 0,1,0,1; each rdata returns to the correct requester; no cycle without a grant.
- r0 issues read 0x10 with lock=1, then write 0xAA to 0x10 with lock=0, while r1_req=1 throughout:
  - r1_gnt=0 until the write is accepted; owner_valid high between the two accepts.
  - r1 is granted on the next cycle.
- Sweep addr 0x00..0xFF, writing 0x55 via r0 and then reading via r1 -> every r1_rdata=0x55, and ram_addr wraps 0xFF->0x00 without glitch.
- Assert reset one cycle after a read accept (RD_LAT=2 build) -> no rvalid emitted; owner_valid=0, ram_wren=0; the first post-reset grant goes to r0 when both request.
- Locked owner drops req for 5 cycles while r1 requests -> r1_gnt stays 0; owner_valid stays 1 until the owner's lock=0 transfer is accepted.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM.
// The master side is the requesters plus the RAM; the slave side is the arbiter.
interface ram_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          r0_req;
    logic          r0_we;
    logic          r0_lock;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_gnt;
    logic          r0_rvalid;
    logic [DW-1:0] r0_rdata;

    logic          r1_req;
    logic          r1_we;
    logic          r1_lock;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_gnt;
    logic          r1_rvalid;
    logic [DW-1:0] r1_rdata;

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wren;
    logic [DW-1:0] ram_q;

    logic          owner_valid;
    logic          owner_id;

    modport master (
        output r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
        output ram_q,
        input  r0_gnt, r0_rvalid, r0_rdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  ram_addr, ram_wdata, ram_wren,
        input  owner_valid, owner_id
    );

    modport slave (
        input  r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
        input  ram_q,
        output r0_gnt, r0_rvalid, r0_rdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output ram_addr, ram_wdata, ram_wren,
        output owner_valid, owner_id
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for a single-port RAM: round-robin grant,
// lock for atomic sequences, and in-order tagged read-data return.
module ram_port_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input logic clk,
    input logic reset,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        FREE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } own_t;

    own_t          state, state_nxt;
    logic          rr, rr_nxt;
    logic          gnt0, gnt1, acc, win;
    logic          w_we, w_lock;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          wren_q;

    logic [RD_LAT-1:0] pv, pid;
    logic              rv0, rv1;
    logic [DW-1:0]     hold0, hold1;

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = state;
        rr_nxt    = rr;
        if (!reset) begin
            unique case (state)
                FREE: begin
                    gnt0 = bus.r0_req && (!bus.r1_req || !rr);
                    gnt1 = bus.r1_req && (!bus.r0_req || rr);
                end
                LOCK0:   gnt0 = bus.r0_req;
                LOCK1:   gnt1 = bus.r1_req;
                default: ;
            endcase
        end
        acc     = gnt0 | gnt1;
        win     = gnt1;
        w_we    = win ? bus.r1_we    : bus.r0_we;
        w_lock  = win ? bus.r1_lock  : bus.r0_lock;
        w_addr  = win ? bus.r1_addr  : bus.r0_addr;
        w_wdata = win ? bus.r1_wdata : bus.r0_wdata;
        if (acc) begin
            if (w_lock) begin
                state_nxt = win ? LOCK1 : LOCK0;
            end else begin
                // priority passes to the other side once the bus is free
                state_nxt = FREE;
                rr_nxt    = !win;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FREE;
            rr      <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wren_q  <= 1'b0;
            pv      <= '0;
            pid     <= '0;
            rv0     <= 1'b0;
            rv1     <= 1'b0;
            hold0   <= '0;
            hold1   <= '0;
        end else begin
            state  <= state_nxt;
            rr     <= rr_nxt;
            wren_q <= acc && w_we;
            if (acc) begin
                addr_q  <= w_addr;
                wdata_q <= w_wdata;
            end
            pv[0]  <= acc && !w_we;
            pid[0] <= win;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i]  <= pv[i-1];
                pid[i] <= pid[i-1];
            end
            rv0 <= pv[RD_LAT-1] && !pid[RD_LAT-1];
            rv1 <= pv[RD_LAT-1] && pid[RD_LAT-1];
            if (rv0) hold0 <= bus.ram_q;
            if (rv1) hold1 <= bus.ram_q;
        end
    end

    assign bus.r0_gnt      = gnt0;
    assign bus.r1_gnt      = gnt1;
    assign bus.r0_rvalid   = rv0;
    assign bus.r1_rvalid   = rv1;
    // pass ram_q straight through on the return cycle, then hold it
    assign bus.r0_rdata    = rv0 ? bus.ram_q : hold0;
    assign bus.r1_rdata    = rv1 ? bus.ram_q : hold1;
    assign bus.ram_addr    = addr_q;
    assign bus.ram_wdata   = wdata_q;
    assign bus.ram_wren    = wren_q;
    assign bus.owner_valid = (state != FREE);
    assign bus.owner_id    = (state == LOCK1);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Random and directed checks of ram_port_arbiter against a transaction-level
// model: grant rules, lock ownership, RAM command and read-return scoreboard.
module tb_ram_port_arbiter;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.AW(8), .DW(8)) bus ();

    ram_port_arbiter #(.AW(8), .DW(8), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] ram [256] = '{default: 8'h00};
    logic [7:0] qp [RD_LAT];
    always @(posedge clk) begin
        if (bus.ram_wren) ram[bus.ram_addr] <= bus.ram_wdata;
        qp[0] <= ram[bus.ram_addr];
        for (int i = 1; i < RD_LAT; i++) qp[i] <= qp[i-1];
    end
    assign bus.ram_q = qp[RD_LAT-1];

    typedef struct {
        logic       id;
        logic [7:0] data;
        int         due;
    } rd_t;

    rd_t        q[$];
    logic [7:0] mem_ref [256] = '{default: 8'h00};
    logic [7:0] last_rd [2];
    logic       m_rr, m_own, m_id, m_wren;
    logic [7:0] m_addr, m_wdata;
    logic       acc0, acc1;
    int         edge_n;
    int         n_chk;
    int         n_fail;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at edge %0d",
                     tag, got, exp, edge_n);
        end
    endtask

    task automatic cmd(input logic id, input logic rq, input logic we,
                       input logic lk, input logic [7:0] a,
                       input logic [7:0] d);
        if (id) begin
            bus.r1_req = rq; bus.r1_we = we; bus.r1_lock = lk;
            bus.r1_addr = a; bus.r1_wdata = d;
        end else begin
            bus.r0_req = rq; bus.r0_we = we; bus.r0_lock = lk;
            bus.r0_addr = a; bus.r0_wdata = d;
        end
    endtask

    task automatic step();
        logic       r, eg0, eg1, ev0, ev1, wid, w, l;
        logic [7:0] a, d;
        @(negedge clk);
        r   = reset;
        eg0 = 1'b0;
        eg1 = 1'b0;
        if (!r) begin
            if (m_own) begin
                if (m_id) eg1 = bus.r1_req;
                else      eg0 = bus.r0_req;
            end else if (bus.r0_req && bus.r1_req) begin
                if (m_rr) eg1 = 1'b1;
                else      eg0 = 1'b1;
            end else begin
                eg0 = bus.r0_req;
                eg1 = bus.r1_req;
            end
        end
        check("r0_gnt", bus.r0_gnt, eg0);
        check("r1_gnt", bus.r1_gnt, eg1);
        check("owner_valid", bus.owner_valid, m_own);
        if (m_own) check("owner_id", bus.owner_id, m_id);
        check("ram_wren", bus.ram_wren, m_wren);
        check("ram_addr", bus.ram_addr, m_addr);
        check("ram_wdata", bus.ram_wdata, m_wdata);
        ev0 = 1'b0;
        ev1 = 1'b0;
        if (q.size() > 0 && q[0].due == edge_n) begin
            if (q[0].id) ev1 = 1'b1;
            else         ev0 = 1'b1;
            last_rd[q[0].id] = q[0].data;
            void'(q.pop_front());
        end
        check("r0_rvalid", bus.r0_rvalid, ev0);
        check("r1_rvalid", bus.r1_rvalid, ev1);
        check("r0_rdata", bus.r0_rdata, last_rd[0]);
        check("r1_rdata", bus.r1_rdata, last_rd[1]);
        acc0 = eg0;
        acc1 = eg1;
        wid  = eg1;
        w = wid ? bus.r1_we    : bus.r0_we;
        l = wid ? bus.r1_lock  : bus.r0_lock;
        a = wid ? bus.r1_addr  : bus.r0_addr;
        d = wid ? bus.r1_wdata : bus.r0_wdata;
        @(posedge clk);
        edge_n++;
        if (r) begin
            m_rr = 0; m_own = 0; m_id = 0;
            m_wren = 0; m_addr = 0; m_wdata = 0;
            q.delete();
            last_rd[0] = 0;
            last_rd[1] = 0;
        end else begin
            m_wren = (eg0 | eg1) && w;
            if (eg0 | eg1) begin
                m_addr  = a;
                m_wdata = d;
                if (w) mem_ref[a] = d;
                else   q.push_back('{wid, mem_ref[a], edge_n + RD_LAT});
                if (l) begin
                    m_own = 1'b1;
                    m_id  = wid;
                end else begin
                    m_own = 1'b0;
                    m_rr  = !wid;
                end
            end
        end
        #1;
    endtask

    initial begin
        int stage;
        n_chk = 0; n_fail = 0; edge_n = 0;
        m_rr = 0; m_own = 0; m_id = 0;
        m_wren = 0; m_addr = 0; m_wdata = 0;
        last_rd[0] = 0; last_rd[1] = 0;
        acc0 = 0; acc1 = 0;
        cmd(0, 0, 0, 0, 8'h00, 8'h00);
        cmd(1, 0, 0, 0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        cmd(0, 1, 0, 0, 8'h00, 8'h00);
        cmd(1, 1, 0, 0, 8'h00, 8'h00);
        step();
        reset = 1'b0;
        cmd(0, 0, 0, 0, 8'h00, 8'h00);
        cmd(1, 0, 0, 0, 8'h00, 8'h00);
        step();

        // r0 write then read back
        cmd(0, 1, 1, 0, 8'h00, 8'h55);
        step();
        cmd(0, 1, 0, 0, 8'h00, 8'h00);
        step();
        cmd(0, 0, 0, 0, 8'h00, 8'h00);
        repeat (RD_LAT + 2) step();
        check("wr_rd_data", bus.r0_rdata, 8'h55);

        // both reading continuously: grants alternate
        for (int i = 0; i < 16; i++) mem_ref[8'h40 + i] = mem_ref[8'h40 + i];
        cmd(0, 1, 0, 0, 8'h41, 8'h00);
        cmd(1, 1, 0, 0, 8'h42, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step();
            check("any_gnt", acc0 | acc1, 1);
            if (acc0) cmd(0, 1, 0, 0, 8'h41 + 8'(2 * i), 8'h00);
            if (acc1) cmd(1, 1, 0, 0, 8'h42 + 8'(2 * i), 8'h00);
        end
        cmd(0, 0, 0, 0, 8'h00, 8'h00);
        cmd(1, 0, 0, 0, 8'h00, 8'h00);
        repeat (RD_LAT + 2) step();

        // locked read-modify-write by r0 while r1 keeps asking
        stage = 0;
        cmd(0, 1, 0, 1, 8'h10, 8'h00);
        cmd(1, 1, 0, 0, 8'h20, 8'h00);
        for (int k = 0; k < 12 && stage < 2; k++) begin
            step();
            if (acc0) begin
                stage++;
                if (stage == 1) cmd(0, 1, 1, 0, 8'h10, 8'hAA);
                else            cmd(0, 0, 0, 0, 8'h00, 8'h00);
            end
            if (acc1) cmd(1, 1, 0, 0, 8'h21, 8'h00);
        end
        check("lock_seq_done", stage, 2);
        step();
        check("r1_after_unlock", acc1, 1);
        cmd(1, 0, 0, 0, 8'h00, 8'h00);
        repeat (RD_LAT + 2) step();

        // full address sweep: write via r0, read via r1
        for (int a = 0; a < 256; a++) begin
            cmd(0, 1, 1, 0, 8'(a), 8'h55);
            step();
        end
        cmd(0, 0, 0, 0, 8'h00, 8'h00);
        for (int a = 0; a < 256; a++) begin
            cmd(1, 1, 0, 0, 8'(a), 8'h00);
            step();
        end
        cmd(1, 0, 0, 0, 8'h00, 8'h00);
        repeat (RD_LAT + 2) step();
        check("sweep_last", bus.r1_rdata, 8'h55);

        // reset right after a locked read accept
        cmd(0, 1, 0, 1, 8'h03, 8'h00);
        step();
        cmd(0, 0, 0, 0, 8'h00, 8'h00);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cmd(0, 1, 0, 1, 8'h05, 8'h00);
        cmd(1, 1, 0, 0, 8'h06, 8'h00);
        step();
        check("post_reset_r0", acc0, 1);

        // locked owner goes quiet for 5 cycles
        cmd(0, 0, 0, 0, 8'h00, 8'h00);
        for (int k = 0; k < 5; k++) begin
            step();
            check("r1_blocked", acc1, 0);
        end
        cmd(0, 1, 1, 0, 8'h05, 8'h77);
        step();
        check("owner_unlock", acc0, 1);
        cmd(0, 0, 0, 0, 8'h00, 8'h00);
        step();
        check("r1_granted", acc1, 1);
        cmd(1, 0, 0, 0, 8'h00, 8'h00);
        repeat (RD_LAT + 2) step();

        // random traffic with occasional resets
        for (int k = 0; k < 1500; k++) begin
            if (!bus.r0_req || acc0)
                cmd(0, $urandom_range(0, 3) != 0, 1'($urandom),
                    $urandom_range(0, 3) == 0, 8'($urandom_range(0, 15)),
                    8'($urandom));
            if (!bus.r1_req || acc1)
                cmd(1, $urandom_range(0, 3) != 0, 1'($urandom),
                    $urandom_range(0, 3) == 0, 8'($urandom_range(0, 15)),
                    8'($urandom));
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        cmd(0, 0, 0, 0, 8'h00, 8'h00);
        cmd(1, 0, 0, 0, 8'h00, 8'h00);
        repeat (RD_LAT + 3) step();
        check("drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
